// File: rtl/swan_sbox_layer.sv
// SWAN S-box layer: applies the 4-bit SWAN S-box (or its inverse) to every nibble of the state,
// SBOX_LANES nibbles per cycle, with valid/ready handshakes on both sides.
module swan_sbox_layer #(
    parameter int unsigned STATE_WIDTH = 256,
    parameter int unsigned SBOX_LANES  = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_inv,
    input  logic [0:STATE_WIDTH-1] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [0:STATE_WIDTH-1] out_data,
    output logic                   busy
);

    localparam int unsigned NCYC  = STATE_WIDTH / (4 * SBOX_LANES);
    localparam int unsigned CNT_W = (NCYC > 1) ? $clog2(NCYC) : 1;
    localparam int unsigned SEL_W = $clog2(STATE_WIDTH);

    if ((STATE_WIDTH % (4 * SBOX_LANES)) != 0) begin : gen_param_check
        $error("STATE_WIDTH must be a multiple of 4*SBOX_LANES");
    end

    typedef enum logic [1:0] {StIdle, StBusy, StDone} fsm_e;

    fsm_e                   fsm_q, fsm_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   mode_q, mode_d;
    logic [0:STATE_WIDTH-1] data_q, data_d;
    logic [SEL_W-1:0]       nib_lsb [SBOX_LANES];

    function automatic logic [3:0] sbox_fwd(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h1;  4'h1: y = 4'h2;  4'h2: y = 4'hC;  4'h3: y = 4'h5;
            4'h4: y = 4'h7;  4'h5: y = 4'h8;  4'h6: y = 4'hA;  4'h7: y = 4'hF;
            4'h8: y = 4'h4;  4'h9: y = 4'hD;  4'hA: y = 4'hB;  4'hB: y = 4'hE;
            4'hC: y = 4'h9;  4'hD: y = 4'h6;  4'hE: y = 4'h0;  default: y = 4'h3;
        endcase
        return y;
    endfunction

    function automatic logic [3:0] sbox_inv(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hE;  4'h1: y = 4'h0;  4'h2: y = 4'h1;  4'h3: y = 4'hF;
            4'h4: y = 4'h8;  4'h5: y = 4'h3;  4'h6: y = 4'hD;  4'h7: y = 4'h4;
            4'h8: y = 4'h5;  4'h9: y = 4'hC;  4'hA: y = 4'h6;  4'hB: y = 4'hA;
            4'hC: y = 4'h2;  4'hD: y = 4'h9;  4'hE: y = 4'hB;  default: y = 4'h7;
        endcase
        return y;
    endfunction

    // Bit offset of the nibble each lane works on this cycle (nibble MSB is the lowest index).
    always_comb begin
        for (int unsigned l = 0; l < SBOX_LANES; l++) begin
            nib_lsb[l] = SEL_W'(4 * (32'(cnt_q) * SBOX_LANES + l));
        end
    end

    always_comb begin
        fsm_d  = fsm_q;
        cnt_d  = cnt_q;
        mode_d = mode_q;
        data_d = data_q;
        unique case (fsm_q)
            StIdle: begin
                if (in_valid) begin
                    data_d = in_data;
                    mode_d = in_inv;
                    cnt_d  = '0;
                    fsm_d  = StBusy;
                end
            end
            StBusy: begin
                for (int unsigned l = 0; l < SBOX_LANES; l++) begin
                    data_d[nib_lsb[l] +: 4] = mode_q ? sbox_inv(data_q[nib_lsb[l] +: 4])
                                                     : sbox_fwd(data_q[nib_lsb[l] +: 4]);
                end
                if (cnt_q == CNT_W'(NCYC - 1)) begin
                    cnt_d = '0;
                    fsm_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    fsm_d = StIdle;
                end
            end
            default: fsm_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q  <= StIdle;
            cnt_q  <= '0;
            mode_q <= 1'b0;
            data_q <= '0;
        end else begin
            fsm_q  <= fsm_d;
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
            data_q <= data_d;
        end
    end

    always_comb begin
        in_ready  = (fsm_q == StIdle);
        out_valid = (fsm_q == StDone);
        busy      = (fsm_q == StBusy);
        out_data  = data_q;
    end

endmodule

// File: tb/tb_swan_sbox_layer.sv
// Scoreboard bench for swan_sbox_layer: a 64-bit/4-lane instance plus two 256-bit instances
// exercising the single-cycle and fully serial extremes.
module tb_swan_sbox_layer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, in_valid, in_inv, out_ready;
    logic [0:63] in_data;
    logic        in_ready, out_valid, busy;
    logic [0:63] out_data;

    logic         bv;
    logic [0:255] bd;
    logic         ir1, ov1, bz1, ir2, ov2, bz2;
    logic [0:255] od1, od2;

    swan_sbox_layer #(.STATE_WIDTH(64), .SBOX_LANES(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_inv(in_inv),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy)
    );

    swan_sbox_layer #(.STATE_WIDTH(256), .SBOX_LANES(64)) u_wide1 (
        .clk(clk), .rst_n(rst_n), .in_valid(bv), .in_ready(ir1), .in_inv(1'b0),
        .in_data(bd), .out_valid(ov1), .out_ready(1'b1), .out_data(od1), .busy(bz1)
    );

    swan_sbox_layer #(.STATE_WIDTH(256), .SBOX_LANES(1)) u_wide2 (
        .clk(clk), .rst_n(rst_n), .in_valid(bv), .in_ready(ir2), .in_inv(1'b0),
        .in_data(bd), .out_valid(ov2), .out_ready(1'b1), .out_data(od2), .busy(bz2)
    );

    logic [3:0] fwd_t [16] = '{4'h1, 4'h2, 4'hC, 4'h5, 4'h7, 4'h8, 4'hA, 4'hF,
                               4'h4, 4'hD, 4'hB, 4'hE, 4'h9, 4'h6, 4'h0, 4'h3};
    logic [3:0] inv_t [16] = '{4'hE, 4'h0, 4'h1, 4'hF, 4'h8, 4'h3, 4'hD, 4'h4,
                               4'h5, 4'hC, 4'h6, 4'hA, 4'h2, 4'h9, 4'hB, 4'h7};

    function automatic logic [63:0] model(input logic [63:0] x, input logic inv);
        logic [63:0] r;
        for (int i = 0; i < 16; i++) begin
            r[63-4*i -: 4] = inv ? inv_t[x[63-4*i -: 4]] : fwd_t[x[63-4*i -: 4]];
        end
        return r;
    endfunction

    typedef struct {
        logic [63:0] data;
        int          tacc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic prev_ov = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: checks latency on each out_valid rise and data on each output handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ov <= 1'b0;
        end else begin
            if (out_valid && !prev_ov) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out_valid: got out_valid=1 required no output");
                end else begin
                    check("latency", 256'(cyc - exp_q[0].tacc), 256'd4);
                end
            end
            if (out_valid && out_ready && exp_q.size() != 0) begin
                check("out_data", 256'(out_data), 256'(exp_q[0].data));
                void'(exp_q.pop_front());
            end
            prev_ov <= out_valid;
        end
    end

    task automatic send(input logic [63:0] d, input logic inv, input logic [63:0] exp);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_inv   = inv;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready=0 required 1 within 50 cycles");
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        exp_q.push_back(exp_t'{exp, cyc});
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results pending, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] w, f;
        int          n, lat1, lat2;
        rst_n = 1'b0; in_valid = 1'b0; in_inv = 1'b0; in_data = '0; out_ready = 1'b1;
        bv = 1'b0; bd = '0;
        #12;
        check("rst_in_ready", 256'(in_ready), 256'd1);
        check("rst_out_valid", 256'(out_valid), 256'd0);
        check("rst_busy", 256'(busy), 256'd0);
        check("rst_out_data", 256'(out_data), 256'd0);
        @(negedge clk);
        rst_n = 1'b1;

        send(64'h0123456789ABCDEF, 1'b0, 64'h12C578AF4DBE9603);
        send(64'h12C578AF4DBE9603, 1'b1, 64'h0123456789ABCDEF);
        send(64'h0000000000000000, 1'b0, 64'h1111111111111111);
        send(64'hFFFFFFFFFFFFFFFF, 1'b1, 64'h7777777777777777);
        drain();

        for (int i = 0; i < 1000; i++) begin
            w = {$urandom, $urandom};
            f = model(w, 1'b0);
            send(w, 1'b0, f);
            send(f, 1'b1, w);
        end
        drain();

        // Back-pressure: hold DONE while a competing word is offered.
        out_ready = 1'b0;
        send(64'hFEDCBA9876543210, 1'b0, 64'h3069EBD4FA875C21);
        check("busy_after_accept", 256'(busy), 256'd1);
        check("in_ready_in_busy", 256'(in_ready), 256'd0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        in_valid = 1'b1; in_data = 64'hAAAAAAAAAAAAAAAA; in_inv = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_out_data", 256'(out_data), 256'(64'h3069EBD4FA875C21));
            check("hold_out_valid", 256'(out_valid), 256'd1);
            check("hold_in_ready", 256'(in_ready), 256'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release_out_valid", 256'(out_valid), 256'd0);
        check("release_in_ready", 256'(in_ready), 256'd1);
        send(64'hAAAAAAAAAAAAAAAA, 1'b0, 64'hBBBBBBBBBBBBBBBB);
        drain();

        // Asynchronous reset in the second BUSY cycle discards the block.
        @(posedge clk);
        #1;
        in_valid = 1'b1; in_data = 64'h0123456789ABCDEF; in_inv = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("busy_before_reset", 256'(busy), 256'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_in_ready", 256'(in_ready), 256'd1);
        check("async_rst_out_valid", 256'(out_valid), 256'd0);
        check("async_rst_busy", 256'(busy), 256'd0);
        check("async_rst_out_data", 256'(out_data), 256'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send(64'h0123456789ABCDEF, 1'b0, 64'h12C578AF4DBE9603);
        drain();

        // Wide instances: NCYC=1 and NCYC=64.
        @(posedge clk);
        #1;
        bv = 1'b1;
        bd = '0;
        check("wide_in_ready", 256'({ir1, ir2}), 256'd3);
        @(posedge clk);
        #1;
        bv = 1'b0;
        lat1 = -1;
        lat2 = -1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (ov1 && lat1 < 0) begin
                lat1 = k;
                check("wide1_data", od1, {64{4'h1}});
            end
            if (ov2 && lat2 < 0) begin
                lat2 = k;
                check("wide64_data", od2, {64{4'h1}});
            end
        end
        check("wide1_latency", 256'(lat1), 256'd1);
        check("wide64_latency", 256'(lat2), 256'd64);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
